// File: rtl/fc_pkg.sv
// Shared types for the FC classification stage: score word, class index and
// the {value, index} candidate carried through the argmax tree.
package fc_pkg;

  localparam int DEF_WORD_SIZE  = 16;
  localparam int DEF_LAYER_SIZE = 10;

  typedef logic signed [DEF_WORD_SIZE-1:0]      word_t;
  typedef logic [$clog2(DEF_LAYER_SIZE)-1:0]    idx_t;

  typedef struct packed {
    word_t val;
    idx_t  idx;
  } cand_t;

  // Number of live candidates after lv halving levels (odd leftovers survive).
  function automatic int level_cnt(input int n, input int lv);
    int c;
    c = n;
    for (int i = 0; i < lv; i++) c = (c + 1) / 2;
    return c;
  endfunction

endpackage

// File: rtl/argmax_node.sv
// One compare/select node of the argmax tree. The right operand wins only on
// strictly greater value, so equal scores keep the lower (left) index.
module argmax_node
  import fc_pkg::*;
#(
  parameter type CAND_T = cand_t
) (
  input  CAND_T a_i,
  input  CAND_T b_i,
  output CAND_T y_o
);

  always_comb begin
    y_o = a_i;
    if (b_i.val > a_i.val) y_o = b_i;
  end

endmodule

// File: rtl/softmax_argmax.sv
// Argmax of the final FC layer scores (equals argmax of softmax), registered.
// Define SOFTMAX_MAXVAL_EN to also output the winning score on Zval.
module softmax_argmax
  import fc_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int LAYER_SIZE = DEF_LAYER_SIZE,
  localparam int IDX_W     = $clog2(LAYER_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [WORD_SIZE-1:0] X [LAYER_SIZE],
  input  logic                        in_valid,
  output logic [IDX_W-1:0]            Z,
  output logic                        out_valid
`ifdef SOFTMAX_MAXVAL_EN
  ,
  output logic [WORD_SIZE-1:0]        Zval
`endif
);

  localparam int LVLS = $clog2(LAYER_SIZE);

  typedef struct packed {
    logic signed [WORD_SIZE-1:0] val;
    logic [IDX_W-1:0]            idx;
  } node_t;

  // lvl[l][j]: j-th surviving candidate after l levels; unused slots tied off.
  node_t lvl [LVLS+1][LAYER_SIZE];

  genvar k, lv, j;
  generate
    for (k = 0; k < LAYER_SIZE; k++) begin : g_leaf
      assign lvl[0][k].val = X[k];
      assign lvl[0][k].idx = IDX_W'(k);
    end

    for (lv = 0; lv < LVLS; lv++) begin : g_lvl
      localparam int CNT = level_cnt(LAYER_SIZE, lv);
      localparam int NXT = (CNT + 1) / 2;
      for (j = 0; j < CNT / 2; j++) begin : g_node
        argmax_node #(.CAND_T(node_t)) u_node (
          .a_i(lvl[lv][2*j]),
          .b_i(lvl[lv][2*j+1]),
          .y_o(lvl[lv+1][j])
        );
      end
      if (CNT % 2 == 1) begin : g_pass
        assign lvl[lv+1][CNT/2] = lvl[lv][CNT-1];
      end
      for (j = NXT; j < LAYER_SIZE; j++) begin : g_tie
        assign lvl[lv+1][j] = '0;
      end
    end
  endgenerate

  logic [IDX_W-1:0] z_q, z_d;
  logic             vld_q, vld_d;

  always_comb begin
    z_d   = in_valid ? lvl[LVLS][0].idx : z_q;
    vld_d = in_valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      z_q   <= z_d;
      vld_q <= vld_d;
    end
  end

  assign Z         = z_q;
  assign out_valid = vld_q;

`ifdef SOFTMAX_MAXVAL_EN
  logic [WORD_SIZE-1:0] zval_q, zval_d;

  always_comb zval_d = in_valid ? lvl[LVLS][0].val : zval_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) zval_q <= '0;
    else        zval_q <= zval_d;
  end

  assign Zval = zval_q;
`endif

endmodule

// File: tb/tb_softmax_argmax.sv
// Directed bench for softmax_argmax: reset, signed compare, ties, streaming, hold.
module tb_softmax_argmax;

  logic               clk;
  logic               reset;
  logic signed [15:0] X [10];
  logic               in_valid;
  logic [3:0]         Z;
  logic               out_valid;
`ifdef SOFTMAX_MAXVAL_EN
  logic [15:0]        Zval;
`endif

  int n_chk = 0;
  int n_err = 0;

  softmax_argmax dut (
    .clk      (clk),
    .reset    (reset),
    .X        (X),
    .in_valid (in_valid),
    .Z        (Z),
    .out_valid(out_valid)
`ifdef SOFTMAX_MAXVAL_EN
    ,
    .Zval     (Zval)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Linear-scan reference: signed, first maximum wins.
  function automatic int ref_argmax();
    int b;
    b = 0;
    for (int i = 1; i < 10; i++) if (X[i] > X[b]) b = i;
    return b;
  endfunction

  task automatic step_chk(input string tag, input int exp_z);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_z"}, 32'(Z), 32'(exp_z));
    chk({tag, "_v"}, 32'(out_valid), 32'd1);
  endtask

  int exp_q [10];
  int held;

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) X[i] = '0;
    #12;
    chk("rst_z", 32'(Z), 32'd0);
    chk("rst_v", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    X = '{16'hAABF, 16'hAAB7, 16'hAAB7, 16'hAAAF, 16'hAABF,
          16'hAABB, 16'hAABF, 16'hAA9F, 16'hAAAF, 16'hAAB7};
    step_chk("neg_tie", 0);

    X = '{16'h8000, 16'hFFFF, 16'hC000, 16'h0001, 16'hFFFE,
          16'h8001, 16'hF000, 16'hFFFF, 16'h9000, 16'hFF00};
    step_chk("signed", 3);

    X = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
          16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF};
    step_chk("last", 9);

    for (int i = 0; i < 10; i++) X[i] = 16'h1234;
    step_chk("all_eq", 0);

    for (int i = 0; i < 10; i++) X[i] = 16'h0000;
    X[5] = 16'h0100;
    X[8] = 16'h0100;
    step_chk("tie58", 5);

    for (int i = 0; i < 10; i++) X[i] = 16'h8000;
    X[6] = 16'hFFF0;
    step_chk("maxv", 6);
`ifdef SOFTMAX_MAXVAL_EN
    chk("maxv_val", 32'(Zval), 32'h0000FFF0);
`endif

    // Async reset in the middle of a cycle while out_valid is high.
    #2;
    reset = 1'b0;
    #1;
    chk("async_z", 32'(Z), 32'd0);
    chk("async_v", 32'(out_valid), 32'd0);
`ifdef SOFTMAX_MAXVAL_EN
    chk("async_val", 32'(Zval), 32'd0);
`endif
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) X[i] = 16'h0000;
    X[4] = 16'h0050;
    step_chk("post_rst", 4);

    // Back-to-back random stream, one result per cycle.
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 10; i++) X[i] = 16'($urandom_range(0, 15) * 16'h1111);
      exp_q[n] = ref_argmax();
      step_chk($sformatf("strm%0d", n), exp_q[n]);
    end
    held = exp_q[9];

    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) X[i] = 16'h0000;
    X[1] = 16'h7000;
    @(posedge clk);
    #1;
    chk("idle_v", 32'(out_valid), 32'd0);
    chk("idle_z", 32'(Z), 32'(held));
    @(posedge clk);
    #1;
    chk("idle2_z", 32'(Z), 32'(held));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
